hazard_ctrl: RTL and testbench

Pipeline hazard and fetch-sequencing controller for the 5-stage core. It generates the `is_stall`, `is_flush` and `branch_target` inputs of `if_stage`, plus the matching hold, bubble and squash controls for the IF/ID, ID/EX and EX/MEM registers. It resolves three event sources: load-use hazards from ID/EX, taken branches from EX, and multi-cycle data-memory waits from MEM. It also keeps stall and flush statistics for debug.

---
 rtl/hazard_ctrl.sv | 85 ++++++++
 tb/tb_hazard_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / branch / memory-wait hazard controller for the 5-stage core.
// Ports: clk, reset (async, active-high); ID/EX/MEM hazard sources in;
// is_stall/is_flush/branch_target to if_stage; id_stall, ex_bubble, ex_stall,
// id_flush pipeline-register controls; mem_timeout, stall_cnt, flush_cnt debug.
module hazard_ctrl #(
  parameter int FLUSH_LEN   = 2,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        is_stall,
  output logic        is_flush,
  output logic [31:0] branch_target,
  output logic        id_stall,
  output logic        ex_bubble,
  output logic        ex_stall,
  output logic        id_flush,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);
  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;
  state_t state, state_n;
  logic [3:0] fcnt, fcnt_n;
  logic [7:0] wcnt;
  logic mem_hold, br_accept, lu_hazard;
  assign mem_hold = mem_req & ~mem_ready;
  // The exit cycle of MEM_WAIT (mem_hold gone) unfreezes EX, so a waiting
  // branch is taken right there rather than one cycle later.
  assign br_accept = (state != FLUSH) & ex_valid & br_taken & ~mem_hold;
  assign lu_hazard = (state != FLUSH) & ~br_accept & id_valid & ex_valid & ex_is_load &
                     (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  assign is_stall  = mem_hold | lu_hazard;
  assign id_stall  = is_stall;
  assign ex_stall  = mem_hold;
  assign ex_bubble = lu_hazard & ~mem_hold;
  assign id_flush  = state == FLUSH;
  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    if (state == FLUSH) begin
      fcnt_n  = mem_hold ? fcnt : fcnt - 4'd1;
      state_n = (!mem_hold && fcnt == 4'd1) ? RUN : FLUSH;
    end else begin
      state_n = br_accept ? FLUSH : mem_hold ? MEM_WAIT : RUN;
      fcnt_n  = br_accept ? 4'(FLUSH_LEN) : fcnt;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      fcnt          <= 4'd0;
      wcnt          <= 8'd0;
      mem_timeout   <= 1'b0;
      is_flush      <= 1'b0;
      branch_target <= 32'd0;
      stall_cnt     <= 16'd0;
      flush_cnt     <= 16'd0;
    end else begin
      state    <= state_n;
      fcnt     <= fcnt_n;
      wcnt     <= !mem_hold ? 8'd0 : (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
      is_flush <= br_accept;
      if (mem_hold && wcnt == 8'(MEM_TIMEOUT - 1))
        mem_timeout <= 1'b1;
      if (br_accept)
        branch_target <= br_target;
      if (is_stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (br_accept && flush_cnt != 16'hFFFF)
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with default parameters.
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid, id_uses_rs2, ex_valid, ex_is_load, br_taken, mem_req, mem_ready;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [31:0] br_target, branch_target;
  logic is_stall, is_flush, id_stall, ex_bubble, ex_stall, id_flush, mem_timeout;
  logic [15:0] stall_cnt, flush_cnt;
  always #5 clk = ~clk;
  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
    .br_taken(br_taken), .br_target(br_target), .mem_req(mem_req), .mem_ready(mem_ready),
    .is_stall(is_stall), .is_flush(is_flush), .branch_target(branch_target),
    .id_stall(id_stall), .ex_bubble(ex_bubble), .ex_stall(ex_stall), .id_flush(id_flush),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  typedef struct packed {
    logic idv; logic [4:0] rs1; logic [4:0] rs2; logic u2; logic exv; logic [4:0] rd;
    logic ld; logic bt; logic [31:0] tgt; logic mreq; logic mrdy;
  } stim_t;
  typedef struct packed {logic stall, bubble, xstall, flush, idf, tmo;} exp_t;
  exp_t exp_q[$];
  int n_chk = 0, n_pass = 0;
  logic [15:0] e_scnt = 16'd0, e_fcnt = 16'd0;
  logic [31:0] e_btgt = 32'd0, prev_tgt = 32'd0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
  endtask
  task automatic drive(input stim_t s);
    id_valid = s.idv; id_rs1 = s.rs1; id_rs2 = s.rs2; id_uses_rs2 = s.u2;
    ex_valid = s.exv; ex_rd = s.rd; ex_is_load = s.ld; br_taken = s.bt;
    br_target = s.tgt; mem_req = s.mreq; mem_ready = s.mrdy;
  endtask
  function automatic stim_t mk(input logic idv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u2, input logic exv, input logic [4:0] rd,
                               input logic ld, input logic bt, input logic [31:0] tgt,
                               input logic mreq, input logic mrdy);
    return {idv, rs1, rs2, u2, exv, rd, ld, bt, tgt, mreq, mrdy};
  endfunction
  task automatic cyc(input stim_t s, input exp_t e);
    exp_t x;
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    if (x.flush) begin
      e_fcnt++;
      e_btgt = prev_tgt;
    end
    chk("is_stall", is_stall, x.stall);
    chk("id_stall", id_stall, x.stall);
    chk("ex_bubble", ex_bubble, x.bubble);
    chk("ex_stall", ex_stall, x.xstall);
    chk("is_flush", is_flush, x.flush);
    chk("id_flush", id_flush, x.idf);
    chk("mem_timeout", mem_timeout, x.tmo);
    chk("branch_target", branch_target, e_btgt);
    chk("stall_cnt", stall_cnt, e_scnt);
    chk("flush_cnt", flush_cnt, e_fcnt);
    if (x.stall) e_scnt++;
    prev_tgt = s.tgt;
  endtask
  initial begin
    stim_t z, lu, m, r;
    logic [63:0] rv;
    z  = '0;
    lu = mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 0, 0);
    m  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(z);
    repeat (3) begin
      @(posedge clk);
      #1;
      rv = {$urandom, $urandom};
      r = rv[53:0];
      drive(r);
      @(negedge clk);
      chk("rst_is_flush", is_flush, 0);
      chk("rst_id_flush", id_flush, 0);
      chk("rst_branch_target", branch_target, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
    end
    drive(z);
    #1 reset = 1'b0;
    cyc(z, 6'b000000);
    cyc(lu, 6'b110000);
    cyc(z, 6'b000000);
    cyc(mk(1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0), 6'b000000);
    cyc(mk(1, 3, 7, 1, 1, 7, 1, 0, 0, 0, 0), 6'b110000);
    cyc(mk(1, 3, 7, 0, 1, 7, 1, 0, 0, 0, 0), 6'b000000);
    cyc(mk(1, 5, 0, 0, 1, 5, 0, 0, 0, 0, 0), 6'b000000);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h10, 0, 0), 6'b000000);
    cyc(lu, 6'b000110);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h99, 0, 0), 6'b000010);
    cyc(z, 6'b000000);
    cyc(m, 6'b101000);
    cyc(mk(1, 5, 0, 0, 1, 5, 1, 0, 0, 1, 0), 6'b101000);
    cyc(m, 6'b101000);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 6'b000000);
    cyc(lu, 6'b110000);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h20, 1, 0), 6'b101000);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h20, 1, 0), 6'b101000);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h20, 0, 0), 6'b000000);
    cyc(m, 6'b101110);
    cyc(m, 6'b101010);
    cyc(z, 6'b000010);
    cyc(z, 6'b000010);
    cyc(z, 6'b000000);
    repeat (64) cyc(m, 6'b101000);
    cyc(m, 6'b101001);
    cyc(mk(0, 0, 0, 0, 1, 0, 0, 1, 32'h30, 0, 0), 6'b000001);
    cyc(z, 6'b000111);
    #1 reset = 1'b1;
    #1;
    chk("async_id_flush", id_flush, 0);
    chk("async_mem_timeout", mem_timeout, 0);
    chk("async_is_flush", is_flush, 0);
    chk("async_branch_target", branch_target, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_flush_cnt", flush_cnt, 0);
    chk("async_is_stall", is_stall, 0);
    @(negedge clk);
    reset = 1'b0;
    e_scnt = 16'd0;
    e_fcnt = 16'd0;
    e_btgt = 32'd0;
    prev_tgt = 32'd0;
    cyc(z, 6'b000000);
    cyc(lu, 6'b110000);
    cyc(z, 6'b000000);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
